// File: rtl/led_pulse_train_gen.sv
// LED pulse-train generator with a 4-word Avalon-MM register block.
// A rising edge on start launches COUNT pulses of HIGH on-cycles every PERIOD cycles.
module led_pulse_train_gen #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned RST_PERIOD = 50000000,
  parameter int unsigned RST_HIGH   = 25000000,
  parameter int unsigned RST_COUNT  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        pulse_out,
  output logic        busy,
  output logic        irq
);

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_HIGH   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  // Programmable configuration
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_count;

  // Burst-time copies so bus writes only affect the next launch
  logic [CNT_W-1:0] r_sh_period;
  logic [CNT_W-1:0] r_sh_high;
  logic [CNT_W-1:0] r_sh_count;

  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_pcnt;
  state_t           r_state;
  logic             r_start_q;
  logic             r_pulse_out;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_irq_en;

  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_stop_req;
  logic             w_clr_done;
  logic             w_clr_err;
  logic             w_launch;
  logic             w_cfg_valid;
  logic [CNT_W-1:0] w_wdata;
  logic [CNT_W-1:0] w_pcnt_inc;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_phase_nxt;
  logic [CNT_W-1:0] w_pcnt_nxt;
  logic             w_load_shadow;
  logic             w_done_set;
  logic             w_err_set;

  assign w_wr        = chipselect & ~write_n;
  assign w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
  assign w_clr_done  = w_wr_ctrl & writedata[0];
  assign w_clr_err   = w_wr_ctrl & writedata[1];
  assign w_stop_req  = w_wr_ctrl & writedata[2];
  assign w_wdata     = writedata[CNT_W-1:0];
  assign w_launch    = start & ~r_start_q;
  assign w_pcnt_inc  = r_pcnt + CNT_W'(1);

  // HIGH < PERIOD together with HIGH >= 1 implies PERIOD >= 2; both kept for clarity
  assign w_cfg_valid = (r_period >= CNT_W'(2)) && (r_high != '0) && (r_high < r_period);

  // Configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= CNT_W'(RST_PERIOD);
      r_high   <= CNT_W'(RST_HIGH);
      r_count  <= CNT_W'(RST_COUNT);
    end else if (w_wr) begin
      case (address)
        ADDR_PERIOD: r_period <= w_wdata;
        ADDR_HIGH:   r_high   <= w_wdata;
        ADDR_COUNT:  r_count  <= w_wdata;
        default:     ;
      endcase
    end
  end

  // Shadow registers captured at launch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_period <= '0;
      r_sh_high   <= '0;
      r_sh_count  <= '0;
    end else if (w_load_shadow) begin
      r_sh_period <= r_period;
      r_sh_high   <= r_high;
      r_sh_count  <= r_count;
    end
  end

  // Next-state logic; stop takes priority over a natural completion
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_pcnt_nxt    = r_pcnt;
    w_load_shadow = 1'b0;
    w_done_set    = 1'b0;
    w_err_set     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          if (w_cfg_valid) begin
            w_load_shadow = 1'b1;
            w_phase_nxt   = r_high - CNT_W'(1);
            w_pcnt_nxt    = '0;
            w_state_nxt   = ST_ON;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_ON: begin
        if (w_stop_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_phase == '0) begin
          w_phase_nxt = r_sh_period - r_sh_high - CNT_W'(1);
          w_state_nxt = ST_OFF;
        end else begin
          w_phase_nxt = r_phase - CNT_W'(1);
        end
      end
      ST_OFF: begin
        if (w_stop_req) begin
          w_state_nxt = ST_IDLE;
        end else if (r_phase == '0) begin
          w_pcnt_nxt = w_pcnt_inc;
          if ((r_sh_count != '0) && (w_pcnt_inc == r_sh_count)) begin
            w_state_nxt = ST_IDLE;
            w_done_set  = 1'b1;
          end else begin
            w_phase_nxt = r_sh_high - CNT_W'(1);
            w_state_nxt = ST_ON;
          end
        end else begin
          w_phase_nxt = r_phase - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered LED/busy outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_pcnt      <= '0;
      r_start_q   <= 1'b0;
      r_pulse_out <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_pcnt      <= w_pcnt_nxt;
      r_start_q   <= start;
      r_pulse_out <= (w_state_nxt == ST_ON);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Sticky status; a set in the same cycle as a clear wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_done_set) begin
        r_done <= 1'b1;
      end else if (w_clr_done) begin
        r_done <= 1'b0;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (w_clr_err) begin
        r_err <= 1'b0;
      end
      if (w_wr_ctrl) begin
        r_irq_en <= writedata[3];
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_PERIOD: readdata = 32'(r_period);
      ADDR_HIGH:   readdata = 32'(r_high);
      ADDR_COUNT:  readdata = 32'(r_count);
      ADDR_CTRL:   readdata = {28'b0, r_irq_en, r_err, r_done, r_busy};
      default:     readdata = '0;
    endcase
  end

  assign pulse_out = r_pulse_out;
  assign busy      = r_busy;
  assign irq       = r_done & r_irq_en;

endmodule

// File: tb/tb_led_pulse_train_gen.sv
// Bench for led_pulse_train_gen: per-cycle {busy,pulse_out} expectations are queued
// from a reference pulse model and popped against the DUT every cycle.
module tb_led_pulse_train_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        pulse_out;
  logic        busy;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] sb_q[$];

  led_pulse_train_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .pulse_out  (pulse_out),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Called right after a falling edge; the write lands on the following rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  // Reference model: cycle k after launch is ON when (k mod P) < H, burst lasts C*P cycles.
  task automatic push_expected(input int p, input int h, input int c, input int n);
    for (int k = 0; k < n; k++) begin
      if (c == 0 || k < c * p) sb_q.push_back({1'b1, ((k % p) < h)});
      else                     sb_q.push_back(2'b00);
    end
  endtask

  task automatic launch();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    n_checks++;
    if ({busy, pulse_out, irq} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_outputs got busy/pulse/irq=%b expected 000", {busy, pulse_out, irq});
    end
    bus_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'd50000000) begin
      n_errors++;
      $display("FAIL reset_period got %0d expected 50000000", rd);
    end
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'd25000000) begin
      n_errors++;
      $display("FAIL reset_high got %0d expected 25000000", rd);
    end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_count got %0d expected 0", rd);
    end
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_status got 0x%0h expected 0x0", rd);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, pulse_out} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_release got busy/pulse=%b expected 00", {busy, pulse_out});
    end
  endtask

  task automatic test_basic_burst();
    logic [1:0]  exp;
    logic [31:0] rd;
    bus_write(2'd0, 32'd4);
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd3);
    launch();
    push_expected(4, 1, 3, 15);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if ({busy, pulse_out} !== exp) begin
        n_errors++;
        $display("FAIL basic_burst k=%0d got busy/pulse=%b expected %b", k, {busy, pulse_out}, exp);
      end
    end
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h2) begin
      n_errors++;
      $display("FAIL basic_status got 0x%0h expected 0x2", rd);
    end
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_irq_masked got %b expected 0", irq);
    end
  endtask

  task automatic test_level_retrigger();
    logic [1:0] exp;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, pulse_out} !== 2'b00) begin
        n_errors++;
        $display("FAIL level_hold k=%0d got busy/pulse=%b expected 00", k, {busy, pulse_out});
      end
    end
    launch();
    push_expected(4, 1, 3, 14);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if ({busy, pulse_out} !== exp) begin
        n_errors++;
        $display("FAIL retrigger k=%0d got busy/pulse=%b expected %b", k, {busy, pulse_out}, exp);
      end
    end
  endtask

  task automatic test_invalid_config();
    logic [31:0] rd;
    logic [31:0] pv[2] = '{32'd3, 32'd1};
    logic [31:0] hv[2] = '{32'd3, 32'd0};
    bus_write(2'd3, 32'h1);
    for (int t = 0; t < 2; t++) begin
      bus_write(2'd0, pv[t]);
      bus_write(2'd1, hv[t]);
      launch();
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        n_checks++;
        if ({busy, pulse_out} !== 2'b00) begin
          n_errors++;
          $display("FAIL invalid%0d k=%0d got busy/pulse=%b expected 00", t, k, {busy, pulse_out});
        end
      end
      bus_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h4) begin
        n_errors++;
        $display("FAIL invalid%0d_status got 0x%0h expected 0x4", t, rd);
      end
      bus_write(2'd3, 32'h2);
      bus_read(2'd3, rd);
      n_checks++;
      if (rd !== 32'h0) begin
        n_errors++;
        $display("FAIL invalid%0d_errclr got 0x%0h expected 0x0", t, rd);
      end
    end
  endtask

  task automatic test_infinite_stop();
    logic [1:0]  exp;
    logic [31:0] rd;
    bus_write(2'd0, 32'd5);
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'd0);
    launch();
    push_expected(5, 2, 0, 100);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if ({busy, pulse_out} !== exp) begin
        n_errors++;
        $display("FAIL infinite k=%0d got busy/pulse=%b expected %b", k, {busy, pulse_out}, exp);
      end
      if (k == 12) start = 1'b0;
      if (k == 13) start = 1'b1;
    end
    bus_write(2'd3, 32'h4);
    n_checks++;
    if ({busy, pulse_out} !== 2'b00) begin
      n_errors++;
      $display("FAIL stop got busy/pulse=%b expected 00", {busy, pulse_out});
    end
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL stop_status got 0x%0h expected 0x0", rd);
    end
  endtask

  task automatic test_shadowing();
    logic [1:0]  exp;
    logic [31:0] rd;
    bus_write(2'd0, 32'd4);
    bus_write(2'd1, 32'd1);
    bus_write(2'd2, 32'd3);
    launch();
    push_expected(4, 1, 3, 14);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if ({busy, pulse_out} !== exp) begin
        n_errors++;
        $display("FAIL shadow_run k=%0d got busy/pulse=%b expected %b", k, {busy, pulse_out}, exp);
      end
      if (k == 1) begin
        address = 2'd0; writedata = 32'd8; chipselect = 1'b1; write_n = 1'b0;
      end
      if (k == 2) begin
        chipselect = 1'b0; write_n = 1'b1;
      end
    end
    bus_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'd8) begin
      n_errors++;
      $display("FAIL shadow_period_reg got %0d expected 8", rd);
    end
    launch();
    push_expected(8, 1, 3, 26);
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if ({busy, pulse_out} !== exp) begin
        n_errors++;
        $display("FAIL shadow_next k=%0d got busy/pulse=%b expected %b", k, {busy, pulse_out}, exp);
      end
    end
  endtask

  task automatic test_irq_reset();
    logic [1:0]  exp;
    logic [31:0] rd;
    bus_write(2'd3, 32'hB);
    bus_write(2'd0, 32'd4);
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'd1);
    launch();
    push_expected(4, 2, 1, 6);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if ({busy, pulse_out} !== exp) begin
        n_errors++;
        $display("FAIL irq_burst k=%0d got busy/pulse=%b expected %b", k, {busy, pulse_out}, exp);
      end
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_errors++;
      $display("FAIL irq_set got %b expected 1", irq);
    end
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'hA) begin
      n_errors++;
      $display("FAIL irq_status got 0x%0h expected 0xA", rd);
    end
    bus_write(2'd3, 32'h1);
    n_checks++;
    if (irq !== 1'b0) begin
      n_errors++;
      $display("FAIL irq_clear got %b expected 0", irq);
    end
    // Reset in the middle of an ON phase with non-default configuration
    bus_write(2'd3, 32'h8);
    bus_write(2'd0, 32'd5);
    bus_write(2'd1, 32'd3);
    bus_write(2'd2, 32'd0);
    launch();
    push_expected(5, 3, 0, 2);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      n_checks++;
      if ({busy, pulse_out} !== exp) begin
        n_errors++;
        $display("FAIL prereset k=%0d got busy/pulse=%b expected %b", k, {busy, pulse_out}, exp);
      end
    end
    start = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, pulse_out, irq} !== 3'b000) begin
      n_errors++;
      $display("FAIL async_reset got busy/pulse/irq=%b expected 000", {busy, pulse_out, irq});
    end
    bus_read(2'd0, rd);
    n_checks++;
    if (rd !== 32'd50000000) begin
      n_errors++;
      $display("FAIL async_reset_period got %0d expected 50000000", rd);
    end
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'd25000000) begin
      n_errors++;
      $display("FAIL async_reset_high got %0d expected 25000000", rd);
    end
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL async_reset_status got 0x%0h expected 0x0", rd);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, pulse_out} !== 2'b00) begin
      n_errors++;
      $display("FAIL post_reset got busy/pulse=%b expected 00", {busy, pulse_out});
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_burst();
    test_level_retrigger();
    test_invalid_config();
    test_infinite_stop();
    test_shadowing();
    test_irq_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
